div_scheduler: RTL and testbench
================================

DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 Parameter: CNT_W, 8, width of per-requester completion counters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 req_dividend0, req_dividend1  input  3 each  unsigned dividend per requester.
REQ-006 req_divisor0, req_divisor1  input  2 each  unsigned divisor per requester.
REQ-007 req_ready  output  2  grant/accept per requester; combinational from req_valid and arbiter state.
REQ-008 rsp_valid  output  1  result valid, one-cycle pulse per accepted request.
REQ-009 rsp_id  output  1  requester index owning the current result.
REQ-010 rsp_q  output  3  quotient.
REQ-011 rsp_rem  output  2  remainder.
REQ-012 rsp_dbz  output  1  divide-by-zero flag for the current result.
REQ-013 busy  output  1  high while any request is in flight.
REQ-014 done_cnt0, done_cnt1  output  CNT_W each  completed-result count per requester.

Function
REQ-015 The block SHALL share one 3-stage pipelined divider between two requesters; a request is accepted on an edge where req_valid[i] and req_ready[i] are both 1.
REQ-016 At most one req_ready bit SHALL be 1 per cycle; req_ready[i] SHALL be 0 when req_valid[i] is 0.
REQ-017 Arbitration SHALL be round-robin: pointer rr (reset 0) names the preferred requester; if only one requester is valid it is granted; if both are valid, requester rr is granted.
REQ-018 After any accepted request from requester i, rr SHALL become 1-i; rr SHALL hold when nothing is accepted.
REQ-019 The pipeline SHALL never stall (no response backpressure), so one request can be accepted every cycle; sustained dual requests alternate 0,1,0,1.
REQ-020 Latency: a request accepted at edge N SHALL produce rsp_valid=1 for exactly the cycle following edge N+3, with rsp_id, rsp_q, rsp_rem, rsp_dbz valid in that same cycle.
REQ-021 Results SHALL return in acceptance order; rsp_id and the dbz flag travel through a 3-entry tag shift register aligned with the divider stages.
REQ-022 Arithmetic: rsp_q = floor(dividend/divisor), rsp_rem = dividend mod divisor, computed by restoring division, one quotient bit per stage, MSB first.
REQ-023 Divisor 0: rsp_dbz=1, rsp_q=3'b111, rsp_rem=dividend[1:0], same latency and ordering as normal requests.
REQ-024 When rsp_valid=0, rsp_q, rsp_rem, rsp_dbz, rsp_id SHALL be 0.
REQ-025 busy SHALL be 1 exactly when any tag-pipeline stage holds a valid entry (in-flight count 1..3).
REQ-026 done_cntX SHALL increment by 1 in the cycle after the edge ending a rsp_valid cycle with rsp_id=X, wrapping from 2^CNT_W-1 to 0.
REQ-027 Request inputs SHALL be sampled only on the accepting edge; later changes do not affect an accepted request.

Reset
REQ-028 rst_n low SHALL immediately clear rr, all tag/valid stages, divider stage registers, and counters; rsp_valid, rsp_id, rsp_q, rsp_rem, rsp_dbz, busy, done_cnt0, done_cnt1 all 0.
REQ-029 Requests in flight when reset asserts SHALL be discarded, producing no rsp_valid after release; req_ready SHALL be 0 while rst_n is low.
REQ-030 The first acceptance is possible on the first rising edge with rst_n high.

Structure
REQ-031 Package div_sched_pkg SHALL hold DIV_LAT=3, dividend/divisor/quotient/remainder widths, the DBZ quotient constant, and a packed tag typedef (valid, id, dbz).
REQ-032 The datapath SHALL be a separate sub-module div_pipe3 (3 registered stages, operands carried alongside partial remainders); arbitration, tag pipeline, and counters reside in div_scheduler.

Verification
REQ-033 Req0 only: dividend 6, divisor 2 -> rsp_valid 3 cycles after acceptance, rsp_id=0, q=3, rem=0, dbz=0, done_cnt0=1.
REQ-034 Both valid every cycle (req0 7/3, req1 5/2) for 4 cycles -> grants 0,1,0,1; responses in order: (0,q=2,r=1),(1,q=2,r=1) repeating; busy stays 1.
REQ-035 Req1 dividend 5, divisor 0 -> rsp_id=1, dbz=1, q=7, rem=1, latency 3.
REQ-036 Exhaustive sweep: all 32 dividend/divisor pairs back-to-back on req0 -> every result matches the reference model, one result per cycle.
REQ-037 Reset asserted mid-stream with 2 in flight -> outputs 0 immediately; no rsp_valid after release; rr=0.
REQ-038 256 completions on req0 with CNT_W=8 -> done_cnt0 wraps to 0.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared widths, latency and tag layout for the two-requester divider scheduler.
package div_sched_pkg;

  localparam int DIV_LAT = 3;
  localparam int DVD_W   = 3;
  localparam int DVS_W   = 2;
  localparam int Q_W     = 3;
  localparam int R_W     = 2;

  localparam logic [Q_W-1:0] DBZ_Q = 3'b111;

  typedef struct packed {
    logic vld;
    logic id;
    logic dbz;
  } tag_t;

endpackage

// File: rtl/div_pipe3.sv
// Three-stage restoring divider, one quotient bit per stage (MSB first).
// Operand bits still needed downstream ride along with the partial remainder.
module div_pipe3
  import div_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic [R_W-1:0]   remainder
);

  // Trial value keeps one spare MSB for the compare; the difference always fits in R_W
  // (for a zero divisor the remainder simply keeps the low dividend bits).
  function automatic logic [R_W:0] div_step(input logic [R_W:0]     trial,
                                            input logic [DVS_W-1:0] dvs);
    logic [R_W-1:0] diff;
    diff = trial[R_W-1:0] - dvs;
    if (trial >= {1'b0, dvs}) div_step = {1'b1, diff};
    else                      div_step = {1'b0, trial[R_W-1:0]};
  endfunction

  logic [R_W:0]     s0;
  logic [R_W:0]     s1;
  logic [R_W:0]     s2;

  logic [0:0]       q_p0;
  logic [R_W-1:0]   pr_p0;
  logic [1:0]       dvd_p0;
  logic [DVS_W-1:0] dvs_p0;

  logic [1:0]       q_p1;
  logic [R_W-1:0]   pr_p1;
  logic [0:0]       dvd_p1;
  logic [DVS_W-1:0] dvs_p1;

  logic [Q_W-1:0]   q_p2;
  logic [R_W-1:0]   pr_p2;

  always_comb begin
    s0 = div_step({{R_W{1'b0}}, dividend[2]}, divisor);
    s1 = div_step({pr_p0, dvd_p0[1]}, dvs_p0);
    s2 = div_step({pr_p1, dvd_p1[0]}, dvs_p1);
  end

  // Stage p0: quotient bit 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p0   <= '0;
      pr_p0  <= '0;
      dvd_p0 <= '0;
      dvs_p0 <= '0;
    end else begin
      q_p0   <= s0[R_W];
      pr_p0  <= s0[R_W-1:0];
      dvd_p0 <= dividend[1:0];
      dvs_p0 <= divisor;
    end
  end

  // Stage p1: quotient bit 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p1   <= '0;
      pr_p1  <= '0;
      dvd_p1 <= '0;
      dvs_p1 <= '0;
    end else begin
      q_p1   <= {q_p0, s1[R_W]};
      pr_p1  <= s1[R_W-1:0];
      dvd_p1 <= dvd_p0[0];
      dvs_p1 <= dvs_p0;
    end
  end

  // Stage p2: quotient bit 0 and final remainder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p2  <= '0;
      pr_p2 <= '0;
    end else begin
      q_p2  <= {q_p1, s2[R_W]};
      pr_p2 <= s2[R_W-1:0];
    end
  end

  assign quotient  = q_p2;
  assign remainder = pr_p2;

endmodule

// File: rtl/div_scheduler.sv
// Round-robin arbitration of two requesters onto one pipelined divider, with an
// in-order tag pipeline, a registered response stage and per-requester completion counters.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [DVD_W-1:0] req_dividend0,
  input  logic [DVD_W-1:0] req_dividend1,
  input  logic [DVS_W-1:0] req_divisor0,
  input  logic [DVS_W-1:0] req_divisor1,
  output logic [1:0]       req_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [Q_W-1:0]   rsp_q,
  output logic [R_W-1:0]   rsp_rem,
  output logic             rsp_dbz,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  logic             rr;
  logic             accept;
  logic             acc_id;
  logic [DVD_W-1:0] acc_dvd;
  logic [DVS_W-1:0] acc_dvs;
  tag_t             tag_in;
  tag_t             tag_p0;
  tag_t             tag_p1;
  tag_t             tag_p2;
  logic [Q_W-1:0]   pipe_q;
  logic [R_W-1:0]   pipe_rem;

  always_comb begin
    req_ready = 2'b00;
    if (rst_n) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = rr ? 2'b10 : 2'b01;
        default: req_ready = 2'b00;
      endcase
    end
  end

  always_comb begin
    accept     = |req_ready;
    acc_id     = req_ready[1];
    acc_dvd    = acc_id ? req_dividend1 : req_dividend0;
    acc_dvs    = acc_id ? req_divisor1  : req_divisor0;
    tag_in.vld = accept;
    tag_in.id  = acc_id;
    tag_in.dbz = (acc_dvs == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr <= 1'b0;
    else if (accept) rr <= ~acc_id;
  end

  div_pipe3 u_div_pipe3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .dividend  (acc_dvd),
    .divisor   (acc_dvs),
    .quotient  (pipe_q),
    .remainder (pipe_rem)
  );

  // Tag stages p0..p2 track the divider stages one-for-one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_p0 <= '0;
      tag_p1 <= '0;
      tag_p2 <= '0;
    end else begin
      tag_p0 <= tag_in;
      tag_p1 <= tag_p0;
      tag_p2 <= tag_p1;
    end
  end

  assign busy = tag_p0.vld | tag_p1.vld | tag_p2.vld;

  // Response stage: fields are forced to zero whenever no result is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_q     <= '0;
      rsp_rem   <= '0;
      rsp_dbz   <= 1'b0;
    end else if (tag_p2.vld) begin
      rsp_valid <= 1'b1;
      rsp_id    <= tag_p2.id;
      rsp_q     <= tag_p2.dbz ? DBZ_Q : pipe_q;
      rsp_rem   <= pipe_rem;
      rsp_dbz   <= tag_p2.dbz;
    end else begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_q     <= '0;
      rsp_rem   <= '0;
      rsp_dbz   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else if (rsp_valid) begin
      if (rsp_id) done_cnt1 <= done_cnt1 + 1'b1;
      else        done_cnt0 <= done_cnt0 + 1'b1;
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// Directed and random stimulus for div_scheduler with an in-order expected-result queue.
module tb_div_scheduler;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [2:0]       req_dividend0;
  logic [2:0]       req_dividend1;
  logic [1:0]       req_divisor0;
  logic [1:0]       req_divisor1;
  logic [1:0]       req_ready;
  logic             rsp_valid;
  logic             rsp_id;
  logic [2:0]       rsp_q;
  logic [1:0]       rsp_rem;
  logic             rsp_dbz;
  logic             busy;
  logic [CNT_W-1:0] done_cnt0;
  logic [CNT_W-1:0] done_cnt1;

  div_scheduler #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_dividend0 (req_dividend0),
    .req_dividend1 (req_dividend1),
    .req_divisor0  (req_divisor0),
    .req_divisor1  (req_divisor1),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_id        (rsp_id),
    .rsp_q         (rsp_q),
    .rsp_rem       (rsp_rem),
    .rsp_dbz       (rsp_dbz),
    .busy          (busy),
    .done_cnt0     (done_cnt0),
    .done_cnt1     (done_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       id;
    logic [2:0] q;
    logic [1:0] rem;
    logic       dbz;
  } exp_t;

  exp_t             sb[$];
  int               checks   = 0;
  int               failures = 0;
  int               edge_n   = 0;
  logic             rr_m     = 1'b0;
  logic [CNT_W-1:0] cnt0_m   = '0;
  logic [CNT_W-1:0] cnt1_m   = '0;
  logic             inc_pend = 1'b0;
  logic             inc_id   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] grant_m(input logic [1:0] v, input logic rr);
    if (v == 2'b11) return rr ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic exp_t mk(input int due, input logic id, input logic [2:0] a,
                              input logic [1:0] b);
    exp_t e;
    e.due = due;
    e.id  = id;
    e.dbz = (b == 2'd0);
    if (b == 2'd0) begin
      e.q   = 3'b111;
      e.rem = a[1:0];
    end else begin
      e.q   = a / {1'b0, b};
      e.rem = 2'(a % {1'b0, b});
    end
    return e;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [2:0] a0, input logic [1:0] b0,
                       input logic [2:0] a1, input logic [1:0] b1);
    req_valid     = v;
    req_dividend0 = a0;
    req_divisor0  = b0;
    req_dividend1 = a1;
    req_divisor1  = b1;
  endtask

  // One clock: check grant before the edge, advance the model, check outputs after it.
  task automatic step();
    logic [1:0] g;
    exp_t       e;
    g = grant_m(req_valid, rr_m);
    chk("req_ready", 32'(req_ready), 32'(g));
    if (g[1])      sb.push_back(mk(edge_n + 4, 1'b1, req_dividend1, req_divisor1));
    else if (g[0]) sb.push_back(mk(edge_n + 4, 1'b0, req_dividend0, req_divisor0));
    @(posedge clk);
    edge_n++;
    if (g != 2'b00) rr_m = ~g[1];
    if (inc_pend) begin
      if (inc_id) cnt1_m++;
      else        cnt0_m++;
      inc_pend = 1'b0;
    end
    #1;
    if (sb.size() != 0 && sb[0].due == edge_n) begin
      e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id",    32'(rsp_id),    32'(e.id));
      chk("rsp_q",     32'(rsp_q),     32'(e.q));
      chk("rsp_rem",   32'(rsp_rem),   32'(e.rem));
      chk("rsp_dbz",   32'(rsp_dbz),   32'(e.dbz));
      inc_pend = 1'b1;
      inc_id   = e.id;
    end else begin
      chk("rsp_valid_idle",  32'(rsp_valid), 32'd0);
      chk("rsp_fields_idle", 32'({rsp_id, rsp_q, rsp_rem, rsp_dbz}), 32'd0);
    end
    chk("busy",      32'(busy),      32'(sb.size() != 0));
    chk("done_cnt0", 32'(done_cnt0), 32'(cnt0_m));
    chk("done_cnt1", 32'(done_cnt1), 32'(cnt1_m));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(req_ready), 32'd0);
    chk({tag, "_rsp"},    32'({rsp_valid, rsp_id, rsp_q, rsp_rem, rsp_dbz}), 32'd0);
    chk({tag, "_busy"},   32'(busy),      32'd0);
    chk({tag, "_cnt0"},   32'(done_cnt0), 32'd0);
    chk({tag, "_cnt1"},   32'(done_cnt1), 32'd0);
  endtask

  task automatic clear_model();
    sb.delete();
    rr_m     = 1'b0;
    cnt0_m   = '0;
    cnt1_m   = '0;
    inc_pend = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b11, 3'd1, 2'd1, 3'd1, 2'd1);
    #1;
    check_reset_outputs("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request on requester 0: 6/2
    drive(2'b01, 3'd6, 2'd2, 3'd0, 2'd0);
    step();
    drive(2'b00, 3'd0, 2'd0, 3'd0, 2'd0);
    repeat (5) step();

    // Both requesters valid for four cycles
    drive(2'b11, 3'd7, 2'd3, 3'd5, 2'd2);
    repeat (4) step();
    drive(2'b00, 3'd0, 2'd0, 3'd0, 2'd0);
    repeat (5) step();

    // Divide by zero on requester 1
    drive(2'b10, 3'd0, 2'd0, 3'd5, 2'd0);
    step();
    drive(2'b00, 3'd0, 2'd0, 3'd0, 2'd0);
    repeat (5) step();

    // Every dividend/divisor pair back-to-back on requester 0
    for (int p = 0; p < 32; p++) begin
      drive(2'b01, 3'(p >> 2), 2'(p), 3'd0, 2'd0);
      step();
    end
    drive(2'b00, 3'd0, 2'd0, 3'd0, 2'd0);
    repeat (5) step();

    // Random mixed traffic from both requesters
    for (int k = 0; k < 60; k++) begin
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      step();
    end
    drive(2'b00, 3'd0, 2'd0, 3'd0, 2'd0);
    repeat (5) step();

    // Reset with two requests in flight and rr pointing at requester 1
    drive(2'b01, 3'd4, 2'd1, 3'd0, 2'd0);
    step();
    drive(2'b01, 3'd3, 2'd2, 3'd0, 2'd0);
    step();
    drive(2'b11, 3'd2, 2'd1, 3'd6, 2'd3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 3'd0, 2'd0, 3'd0, 2'd0);
    repeat (5) step();
    drive(2'b11, 3'd2, 2'd1, 3'd6, 2'd3);
    step();
    drive(2'b00, 3'd0, 2'd0, 3'd0, 2'd0);
    repeat (5) step();

    // Completion counter wrap: 256 results on requester 0 after a fresh reset
    rst_n = 1'b0;
    #1;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 256; k++) begin
      drive(2'b01, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'd0, 2'd0);
      step();
    end
    drive(2'b00, 3'd0, 2'd0, 3'd0, 2'd0);
    repeat (5) step();
    chk("done_cnt0_wrap", 32'(done_cnt0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
